// File: rtl/redmule_tile_sequencer.sv
// redmule_tile_sequencer
// Walks the (row, col, k) tile space of one GEMM job. The job runs k innermost,
// then col, then row. The block emits one tile descriptor per handshake and
// counts the output-tile stores.
// Ports:
//   clk_i, rst_i, clear_i      clock, sync active-high reset and soft clear
//   start_i + *_iter_i/_lftovr_i  job start and tiler-produced loop bounds
//   tile_valid_o/tile_ready_i  descriptor handshake
//   row/col/k_idx_o, rows/cols/depth_o, first_k/last_k/last_tile_o  descriptor
//   store_cnt_o, busy_o, done_o  progress/status
module redmule_tile_sequencer #(
  parameter int ARRAY_WIDTH  = 12,
  parameter int ARRAY_HEIGHT = 4,
  parameter int PIPE_REGS    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic [15:0] x_rows_iter_i,
  input  logic [15:0] w_cols_iter_i,
  input  logic [15:0] x_cols_iter_i,
  input  logic [7:0]  x_rows_lftovr_i,
  input  logic [7:0]  w_cols_lftovr_i,
  input  logic [7:0]  x_cols_lftovr_i,
  output logic        tile_valid_o,
  input  logic        tile_ready_i,
  output logic [15:0] row_idx_o,
  output logic [15:0] col_idx_o,
  output logic [15:0] k_idx_o,
  output logic [7:0]  rows_o,
  output logic [7:0]  cols_o,
  output logic [7:0]  depth_o,
  output logic        first_k_o,
  output logic        last_k_o,
  output logic        last_tile_o,
  output logic [15:0] store_cnt_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [7:0] FULL_W = 8'(ARRAY_WIDTH);
  localparam logic [7:0] FULL_D = 8'(ARRAY_HEIGHT * (PIPE_REGS + 1));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;

  logic [15:0] rows_iter_q, cols_iter_q, k_iter_q;
  logic [7:0]  rows_lft_q, cols_lft_q, k_lft_q;
  logic [15:0] row_q, col_q, k_q, store_q;
  logic        valid_q;

  logic hs, zero_cfg, row_last, col_last, k_last, tile_last;

  assign hs        = valid_q & tile_ready_i;
  assign zero_cfg  = (x_rows_iter_i == 16'd0) | (w_cols_iter_i == 16'd0) |
                     (x_cols_iter_i == 16'd0);
  assign row_last  = (row_q == rows_iter_q - 16'd1);
  assign col_last  = (col_q == cols_iter_q - 16'd1);
  assign k_last    = (k_q == k_iter_q - 16'd1);
  assign tile_last = row_last & col_last & k_last;

  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = zero_cfg ? DONE : RUN;
      RUN:     if (hs && tile_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) begin
      rows_iter_q <= '0; cols_iter_q <= '0; k_iter_q <= '0;
      rows_lft_q  <= '0; cols_lft_q  <= '0; k_lft_q  <= '0;
      row_q <= '0; col_q <= '0; k_q <= '0;
      store_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          rows_iter_q <= x_rows_iter_i;
          cols_iter_q <= w_cols_iter_i;
          k_iter_q    <= x_cols_iter_i;
          rows_lft_q  <= x_rows_lftovr_i;
          cols_lft_q  <= w_cols_lftovr_i;
          k_lft_q     <= x_cols_lftovr_i;
          row_q <= '0; col_q <= '0; k_q <= '0;
          store_q <= '0;
          valid_q <= ~zero_cfg;
        end
        RUN: if (hs) begin
          if (k_last) store_q <= store_q + 16'd1;
          if (tile_last) begin
            // indices hold at their final values; valid drops with DONE
            valid_q <= 1'b0;
          end else if (k_last) begin
            k_q <= '0;
            if (col_last) begin
              col_q <= '0;
              row_q <= row_q + 16'd1;
            end else begin
              col_q <= col_q + 16'd1;
            end
          end else begin
            k_q <= k_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // sizes and flags are decoded from registered state only and forced to 0
  // when no descriptor is presented, so idle/reset outputs read 0
  assign tile_valid_o = valid_q;
  assign row_idx_o    = row_q;
  assign col_idx_o    = col_q;
  assign k_idx_o      = k_q;
  assign rows_o  = !valid_q ? 8'd0 : (row_last && rows_lft_q != 8'd0) ? rows_lft_q : FULL_W;
  assign cols_o  = !valid_q ? 8'd0 : (col_last && cols_lft_q != 8'd0) ? cols_lft_q : FULL_W;
  assign depth_o = !valid_q ? 8'd0 : (k_last && k_lft_q != 8'd0) ? k_lft_q : FULL_D;
  assign first_k_o   = valid_q & (k_q == 16'd0);
  assign last_k_o    = valid_q & k_last;
  assign last_tile_o = valid_q & tile_last;
  assign store_cnt_o = store_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_redmule_tile_sequencer.sv
module tb_redmule_tile_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i, clear_i, start_i, tile_ready_i;
  logic [15:0] x_rows_iter_i, w_cols_iter_i, x_cols_iter_i;
  logic [7:0]  x_rows_lftovr_i, w_cols_lftovr_i, x_cols_lftovr_i;
  logic        tile_valid_o, first_k_o, last_k_o, last_tile_o, busy_o, done_o;
  logic [15:0] row_idx_o, col_idx_o, k_idx_o, store_cnt_o;
  logic [7:0]  rows_o, cols_o, depth_o;

  redmule_tile_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .x_rows_iter_i(x_rows_iter_i), .w_cols_iter_i(w_cols_iter_i),
    .x_cols_iter_i(x_cols_iter_i), .x_rows_lftovr_i(x_rows_lftovr_i),
    .w_cols_lftovr_i(w_cols_lftovr_i), .x_cols_lftovr_i(x_cols_lftovr_i),
    .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .row_idx_o(row_idx_o), .col_idx_o(col_idx_o), .k_idx_o(k_idx_o),
    .rows_o(rows_o), .cols_o(cols_o), .depth_o(depth_o),
    .first_k_o(first_k_o), .last_k_o(last_k_o), .last_tile_o(last_tile_o),
    .store_cnt_o(store_cnt_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] r, c, k;
    logic [7:0]  rows, cols, depth;
    logic        fk, lk, lt;
  } desc_t;

  typedef struct {
    int ri, ci, ki;      // iteration counts
    int rl, cl, kl;      // leftovers
    int rdy_pct;         // probability of tile_ready_i per cycle
    int inj;             // cycle at which a stray start_i is injected (-1: none)
    int exp_n;           // expected descriptor count
    int exp_store;       // expected final store count
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic desc_t snap();
    desc_t d;
    d = '{r: row_idx_o, c: col_idx_o, k: k_idx_o, rows: rows_o, cols: cols_o,
          depth: depth_o, fk: first_k_o, lk: last_k_o, lt: last_tile_o};
    return d;
  endfunction

  function automatic logic [127:0] all_outs();
    return {34'd0, tile_valid_o, row_idx_o, col_idx_o, k_idx_o, rows_o, cols_o,
            depth_o, first_k_o, last_k_o, last_tile_o, store_cnt_o, busy_o, done_o};
  endfunction

  // size for one dimension: the leftover applies only to the last tile
  function automatic logic [7:0] eff(input int idx, input int n, input int lft, input int full);
    return 8'((idx == n - 1 && lft != 0) ? lft : full);
  endfunction

  task automatic drive_cfg(input vec_t v);
    x_rows_iter_i = 16'(v.ri); w_cols_iter_i = 16'(v.ci); x_cols_iter_i = 16'(v.ki);
    x_rows_lftovr_i = 8'(v.rl); w_cols_lftovr_i = 8'(v.cl); x_cols_lftovr_i = 8'(v.kl);
  endtask

  task automatic run_job(input vec_t v);
    desc_t q[$];
    desc_t cur, prev;
    int cyc, accepted;
    bit got_done, stall, rdy;
    // reference: the spec's loop nest, k innermost
    for (int r = 0; r < v.ri; r++)
      for (int c = 0; c < v.ci; c++)
        for (int k = 0; k < v.ki; k++)
          q.push_back('{r: 16'(r), c: 16'(c), k: 16'(k),
                        rows: eff(r, v.ri, v.rl, 12), cols: eff(c, v.ci, v.cl, 12),
                        depth: eff(k, v.ki, v.kl, 16), fk: (k == 0), lk: (k == v.ki - 1),
                        lt: (r == v.ri - 1 && c == v.ci - 1 && k == v.ki - 1)});
    drive_cfg(v);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    // scramble the inputs: the block must run from its latched copy
    x_rows_iter_i = 16'($urandom); w_cols_iter_i = 16'($urandom); x_cols_iter_i = 16'($urandom);
    x_rows_lftovr_i = 8'($urandom); w_cols_lftovr_i = 8'($urandom); x_cols_lftovr_i = 8'($urandom);
    cyc = 1; accepted = 0; got_done = 0; stall = 0; prev = '0;
    while (cyc <= 4000) begin
      start_i = (cyc == v.inj);
      if (done_o) begin got_done = 1; break; end
      if (tile_valid_o) begin
        cur = snap();
        if (stall) chk("stall_hold", cur, prev);
        rdy = ($urandom_range(1, 100) <= v.rdy_pct);
        tile_ready_i = rdy;
        if (rdy) begin
          if (q.size() == 0) chk("extra_desc", 1, 0);
          else chk("desc", cur, q.pop_front());
          accepted++;
        end
        stall = !rdy;
        prev = cur;
      end else begin
        if (stall) chk("valid_hold", 0, 1);
        stall = 0;
        tile_ready_i = 1'($urandom);
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    start_i = 1'b0;
    chk("done_seen", got_done, 1);
    if (v.rdy_pct == 100) chk("done_lat", cyc, v.exp_n + 1);
    chk("n_desc", accepted, v.exp_n);
    chk("q_empty", q.size(), 0);
    chk("store_cnt", store_cnt_o, v.exp_store);
    chk("valid_at_done", tile_valid_o, 0);
    tile_ready_i = 1'b0;
    @(posedge clk_i); #1;
    chk("idle_after", {busy_o, done_o, tile_valid_o}, 3'b000);
    chk("store_hold", store_cnt_o, v.exp_store);
  endtask

  // run 2/2/2 until descriptor 5 is presented, then abort with clear or reset
  task automatic abort_job(input bit use_rst);
    vec_t v;
    int n;
    bit hit;
    v = '{2, 2, 2, 3, 4, 5, 100, -1, 8, 4};
    drive_cfg(v);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0; hit = 0;
    tile_ready_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (tile_valid_o && n == 5) begin hit = 1; break; end
      if (tile_valid_o) n++;
      @(posedge clk_i); #1;
    end
    chk(use_rst ? "rst_reach5" : "clr_reach5", hit, 1);
    if (use_rst) rst_i = 1'b1; else clear_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; clear_i = 1'b0; tile_ready_i = 1'b0;
    chk(use_rst ? "rst_outs" : "clr_outs", all_outs(), 0);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    tbl[0] = '{2, 2, 3, 0, 0, 0, 100, -1, 12, 4};   // basic loop order
    tbl[1] = '{2, 1, 2, 5, 7, 9, 100, -1, 4, 2};    // leftovers
    tbl[2] = '{1, 1, 4, 0, 0, 0, 20, -1, 4, 1};     // heavy backpressure
    tbl[3] = '{2, 0, 3, 0, 0, 0, 100, -1, 0, 0};    // zero cols
    tbl[4] = '{0, 2, 2, 0, 0, 0, 100, -1, 0, 0};    // zero rows
    tbl[5] = '{2, 2, 0, 0, 0, 0, 100, -1, 0, 0};    // zero k
    tbl[6] = '{2, 2, 2, 0, 0, 0, 100, 3, 8, 4};     // stray start mid-job
    tbl[7] = '{3, 1, 1, 4, 0, 3, 100, -1, 3, 3};    // k=1: first and last k together
    tbl[8] = '{1, 3, 1, 11, 1, 0, 70, -1, 3, 3};

    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; tile_ready_i = 1'b0;
    drive_cfg(tbl[0]);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("reset_outs", all_outs(), 0);

    for (int i = 0; i < 9; i++) run_job(tbl[i]);

    abort_job(1'b0);
    run_job(tbl[0]);
    abort_job(1'b1);
    run_job(tbl[1]);

    for (int i = 0; i < 8; i++) begin
      rv.ri = $urandom_range(1, 3); rv.ci = $urandom_range(1, 3); rv.ki = $urandom_range(1, 4);
      rv.rl = $urandom_range(0, 11); rv.cl = $urandom_range(0, 11); rv.kl = $urandom_range(0, 15);
      rv.rdy_pct = $urandom_range(30, 100);
      rv.inj = (i % 3 == 0) ? 2 : -1;
      rv.exp_n = rv.ri * rv.ci * rv.ki;
      rv.exp_store = rv.ri * rv.ci;
      run_job(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
